// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD conversion blocks
// Contents:
//   state_t       controller states IDLE / SHIFT
//   BCD_ADJ_*     per-digit correction threshold and subtrahend
//   BCD_MAX_DIGIT largest legal BCD digit value
//   count_width() width of an iteration counter covering 0..bin_w-1
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

  function automatic int count_width(input int bin_w);
    return (bin_w > 1) ? $clog2(bin_w) : 1;
  endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// rtl/bcd2bin_if.sv - start/busy/done conversion handshake bundle
// Signals:
//   start   request a conversion (master -> slave)
//   bcd_in  packed BCD operand, digit 0 at [3:0] (master -> slave)
//   busy    conversion in progress (slave -> master)
//   done    one-cycle result strobe (slave -> master)
//   bin_out unsigned binary result (slave -> master)
//   err     operand held a digit above 9 (slave -> master)
interface bcd2bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - reverse double dabble correction for one BCD digit
// Ports:
//   digit  4-bit digit field after the right shift
//   adj    digit minus 3 when digit >= 8, else digit unchanged
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= BCD_ADJ_THRESH) ? (digit - BCD_ADJ_SUB) : digit;

endmodule

// File: rtl/bcd2bin.sv
// rtl/bcd2bin.sv - sequential packed-BCD to unsigned binary converter
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  bcd2bin_if slave: start/bcd_in in; busy/done/bin_out/err out
// A valid operand takes BIN_W shift cycles; an operand with a digit above 9
// is rejected with done+err on the accept edge itself.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  bcd2bin_if.slave        bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int TOT_W = BCD_W + BIN_W;
  localparam int CNT_W = count_width(BIN_W);

  // The largest DIGITS-digit decimal value must fit in the binary result.
  if ((64'd10 ** DIGITS) - 64'd1 >= (64'd1 << BIN_W)) begin : g_width_check
    $error("bcd2bin: BIN_W too small for DIGITS");
  end

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [TOT_W-1:0]   sr, sr_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic               err_q, err_nxt;
  logic [BIN_W-1:0]   bin_q, bin_nxt;

  logic               bad_digit;
  logic               last_iter;
  logic [TOT_W-1:0]   shifted;
  logic [BCD_W-1:0]   adj_field;
  logic [TOT_W-1:0]   sr_step;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > BCD_MAX_DIGIT) bad_digit = 1'b1;
    end
  end

  // One iteration: shift the whole register right, then correct each digit
  // field of the upper (BCD) part independently.
  assign shifted = sr >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (shifted[BIN_W + 4*g +: 4]),
      .adj   (adj_field[4*g +: 4])
    );
  end

  assign sr_step   = {adj_field, shifted[BIN_W-1:0]};
  assign last_iter = (count == CNT_W'(BIN_W - 1));

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sr_nxt    = sr;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    err_nxt   = err_q;
    bin_nxt   = bin_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          err_nxt = 1'b0;
          sr_nxt  = {bus.bcd_in, {BIN_W{1'b0}}};
          if (bad_digit) begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
            bin_nxt  = '0;
          end else begin
            count_nxt = '0;
            busy_nxt  = 1'b1;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        sr_nxt    = sr_step;
        count_nxt = count + 1'b1;
        if (last_iter) begin
          bin_nxt   = sr_step[BIN_W-1:0];
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      sr     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      bin_q  <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      sr     <= sr_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      bin_q  <= bin_nxt;
    end
  end

  // For a valid operand every BCD digit has been drained to zero once the
  // final iteration completes; a non-zero residue means a datapath fault.
  always_ff @(posedge clk) begin
    if (rst && state == SHIFT && last_iter) begin
      assert (sr_step[TOT_W-1:BIN_W] == '0);
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb/tb_bcd2bin.sv - self-checking bench for bcd2bin against an arithmetic model
module tb_bcd2bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bcd2bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal value of a packed BCD word, plus legality.
  function automatic int bcd_value(input logic [15:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit bcd_bad(input logic [15:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Stand-in for the existing binary-to-BCD block.
  function automatic logic [15:0] bin2bcd(input int n);
    logic [15:0] b = '0;
    int m = n;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return b;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where the
  // result is visible (the done cycle), so calls can run back to back.
  task automatic convert(input string tag, input logic [15:0] bcd);
    int  exp_val;
    bit  exp_err;
    int  lat;
    bit  busy_ok;
    exp_err = bcd_bad(bcd);
    exp_val = exp_err ? 0 : bcd_value(bcd);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bcd_in = $urandom;
    if (exp_err) begin
      check({tag, " err_done"}, 32'(bus.done), 32'd1);
      check({tag, " err_flag"}, 32'(bus.err), 32'd1);
      check({tag, " err_bin"}, 32'(bus.bin_out), 32'd0);
      check({tag, " err_busy"}, 32'(bus.busy), 32'd0);
      return;
    end
    check({tag, " busy_on"}, 32'(bus.busy), 32'd1);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < BIN_W + 4) begin
      if (!bus.busy) busy_ok = 1'b0;
      bus.bcd_in = $urandom;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(BIN_W));
    check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, " bin"}, 32'(bus.bin_out), 32'(exp_val));
    check({tag, " err"}, 32'(bus.err), 32'd0);
    check({tag, " busy_off"}, 32'(bus.busy), 32'd0);
  endtask

  logic [15:0] vals [68];

  initial begin
    int dcount;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst err", 32'(bus.err), 32'd0);
    check("rst bin", 32'(bus.bin_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    convert("c1234", 16'h1234);
    check("c1234 value", 32'(bus.bin_out), 32'h04D2);
    convert("c9999", 16'h9999);
    check("c9999 value", 32'(bus.bin_out), 32'h270F);
    convert("c0000", 16'h0000);
    convert("c12A4", 16'h12A4);
    convert("c0042", 16'h0042);
    check("c0042 value", 32'(bus.bin_out), 32'h002A);
    @(negedge clk);
    check("done one cycle", 32'(bus.done), 32'd0);
    check("bin held", 32'(bus.bin_out), 32'h002A);

    // start held high, operand changing every cycle: accepts land every
    // BIN_W+1 edges starting with the first.
    for (int i = 0; i < 68; i++) vals[i] = bin2bcd($urandom_range(0, 9999));
    for (int i = 0; i < 68; i++) begin
      bus.start  = 1'b1;
      bus.bcd_in = vals[i];
      @(negedge clk);
      check("held done", 32'(bus.done), 32'((i % 17) == 16));
      if ((i % 17) == 16)
        check("held bin", 32'(bus.bin_out), 32'(bcd_value(vals[i - 16])));
    end
    bus.start = 1'b0;
    @(negedge clk);

    // Reset pulse at the 8th shift edge of a conversion.
    bus.start  = 1'b1;
    bus.bcd_in = 16'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort bin", 32'(bus.bin_out), 32'd0);
    check("abort err", 32'(bus.err), 32'd0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("abort no done", 32'(dcount), 32'd0);
    convert("c0010", 16'h0010);
    check("c0010 value", 32'(bus.bin_out), 32'h000A);

    // Arbitrary 16-bit words, legal or not.
    for (int i = 0; i < 40; i++) convert("rand16", 16'($urandom));

    // Round trip through the binary-to-BCD model.
    for (int i = 0; i < 1000; i++) convert("trip", bin2bcd($urandom_range(0, 9999)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
